// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared constants and types for the 5-stage core pipeline
//                controller: execution modes, MEM-stage control ops,
//                exception codes and the control-register (CREG) address map.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // CREG address bus width used by the decoder and the MEM stage.
    typedef logic [4:0] creg_addr_t;

    // Execution modes.
    localparam logic c_cpu_kernel_mode = 1'b0;
    localparam logic c_cpu_user_mode   = 1'b1;

    // MEM-stage control operations.
    localparam logic [1:0] c_ctrl_op_nop  = 2'd0;
    localparam logic [1:0] c_ctrl_op_wrcr = 2'd1;
    localparam logic [1:0] c_ctrl_op_exrt = 2'd2;

    // Exception codes. Codes 2..7 come straight from the MEM stage;
    // the controller only synthesises EXT_INT itself.
    localparam logic [2:0] c_isa_exp_no_exp  = 3'd0;
    localparam logic [2:0] c_isa_exp_ext_int = 3'd1;

    // CREG address map.
    localparam creg_addr_t c_creg_addr_status     = 5'd0;
    localparam creg_addr_t c_creg_addr_pre_status = 5'd1;
    localparam creg_addr_t c_creg_addr_epc        = 5'd2;
    localparam creg_addr_t c_creg_addr_exp_vector = 5'd3;
    localparam creg_addr_t c_creg_addr_cause      = 5'd4;
    localparam creg_addr_t c_creg_addr_irq_mask   = 5'd5;
    localparam creg_addr_t c_creg_addr_irq        = 5'd6;

    // A synchronous exception reported by the instruction always wins;
    // an external interrupt only fills an otherwise empty slot.
    function automatic logic [2:0] sel_exp_code(input logic [2:0] insn_code,
                                                input logic       int_det);
        logic [2:0] code;
        code = insn_code;
        if ((insn_code == c_isa_exp_no_exp) && int_det) begin
            code = c_isa_exp_ext_int;
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_irq_sync
//  Description : Multi-flop synchroniser for asynchronous level interrupt
//                requests. Output lags the input by SYNC_DEPTH clocks.
//  Revision    : 1.0 - initial release
//  Ports       : clk       - core clock
//                reset_    - asynchronous active-low reset
//                irq_async - raw interrupt lines
//                irq_sync  - synchronised interrupt lines
// ============================================================================
module pipeline_ctrl_irq_sync #(
    parameter int IRQ_CH     = 8,
    parameter int SYNC_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [IRQ_CH-1:0] irq_async,
    output logic [IRQ_CH-1:0] irq_sync
);

    logic [SYNC_DEPTH-1:0][IRQ_CH-1:0] r_stage;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_DEPTH-2:0], irq_async};
        end
    end

    assign irq_sync = r_stage[SYNC_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Pipeline sequencer and CREG owner for the IF/ID/EX/MEM/WB
//                core. Converts bus-busy and load-use hazards into per-stage
//                stall/flush, takes exceptions and IRQs at MEM, executes
//                WRCR/EXRT and drives the redirect PC.
//  Revision    : 1.0 - initial release
//  Ports       : clk, reset_                 - clock, async active-low reset
//                creg_rd_addr/creg_rd_data   - decoder CREG read port
//                exe_mode                    - 0 kernel, 1 user
//                irq / int_detect            - async IRQ lines / IRQ pending
//                if_busy, mem_busy           - bus access in progress
//                ld_hazard                   - load-use hazard from decoder
//                mem_en, mem_pc, mem_ctrl_op,
//                mem_dst_addr, mem_out,
//                mem_exp_code                - MEM-stage instruction info
//                *_stall / *_flush           - per-stage hold / bubble
//                new_pc                      - redirect target (with if_flush)
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int IRQ_CH     = 8,
    parameter int SYNC_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [4:0]        creg_rd_addr,
    output logic [31:0]       creg_rd_data,
    output logic              exe_mode,
    input  logic [IRQ_CH-1:0] irq,
    output logic              int_detect,
    input  logic              if_busy,
    input  logic              ld_hazard,
    input  logic              mem_busy,
    input  logic              mem_en,
    input  logic [29:0]       mem_pc,
    input  logic [1:0]        mem_ctrl_op,
    input  logic [4:0]        mem_dst_addr,
    input  logic [31:0]       mem_out,
    input  logic [2:0]        mem_exp_code,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [29:0]       new_pc
);

    // Control registers.
    logic              r_exe_mode;
    logic              r_int_en;
    logic              r_pre_exe_mode;
    logic              r_pre_int_en;
    logic [29:0]       r_epc;
    logic [29:0]       r_exp_vector;   // word address; byte bits always read 0
    logic [2:0]        r_cause;
    logic [IRQ_CH-1:0] r_irq_mask;

    logic [IRQ_CH-1:0] w_irq_sync;
    logic              w_int_detect;
    logic              w_busy;
    logic              w_take;
    logic [2:0]        w_exp_code;
    logic              w_exp;
    logic              w_exrt;
    logic              w_wrcr;

    pipeline_ctrl_irq_sync #(
        .IRQ_CH     (IRQ_CH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_irq_sync (
        .clk       (clk),
        .reset_    (reset_),
        .irq_async (irq),
        .irq_sync  (w_irq_sync)
    );

    assign w_int_detect = r_int_en & (|(w_irq_sync & ~r_irq_mask));
    assign int_detect   = w_int_detect;
    assign exe_mode     = r_exe_mode;

    // A MEM event may only fire when nothing is held; during busy the
    // instruction simply waits in MEM and is re-evaluated next cycle.
    assign w_busy     = if_busy | mem_busy;
    assign w_take     = mem_en & ~w_busy;
    assign w_exp_code = sel_exp_code(mem_exp_code, w_int_detect);
    assign w_exp      = w_take & (w_exp_code != c_isa_exp_no_exp);
    assign w_exrt     = w_take & ~w_exp & (mem_ctrl_op == c_ctrl_op_exrt);
    assign w_wrcr     = w_take & ~w_exp & (mem_ctrl_op == c_ctrl_op_wrcr);

    // ------------------------------------------------------------------
    // CREG state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_exe_mode     <= c_cpu_kernel_mode;
            r_int_en       <= 1'b0;
            r_pre_exe_mode <= c_cpu_kernel_mode;
            r_pre_int_en   <= 1'b0;
            r_epc          <= '0;
            r_exp_vector   <= '0;
            r_cause        <= c_isa_exp_no_exp;
            r_irq_mask     <= '1;
        end else if (w_exp) begin
            r_epc          <= mem_pc;
            r_cause        <= w_exp_code;
            r_pre_exe_mode <= r_exe_mode;
            r_pre_int_en   <= r_int_en;
            r_exe_mode     <= c_cpu_kernel_mode;
            r_int_en       <= 1'b0;
        end else if (w_exrt) begin
            r_exe_mode     <= r_pre_exe_mode;
            r_int_en       <= r_pre_int_en;
        end else if (w_wrcr) begin
            case (mem_dst_addr)
                c_creg_addr_status: begin
                    r_exe_mode <= mem_out[0];
                    r_int_en   <= mem_out[1];
                end
                c_creg_addr_pre_status: begin
                    r_pre_exe_mode <= mem_out[0];
                    r_pre_int_en   <= mem_out[1];
                end
                c_creg_addr_epc:        r_epc        <= mem_out[31:2];
                c_creg_addr_exp_vector: r_exp_vector <= mem_out[31:2];
                c_creg_addr_cause:      r_cause      <= mem_out[2:0];
                c_creg_addr_irq_mask:   r_irq_mask   <= mem_out[IRQ_CH-1:0];
                default: ;  // IRQ is read-only; unmapped addresses ignore writes
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CREG read port (returns pre-write value during a WRCR cycle)
    // ------------------------------------------------------------------
    always_comb begin
        creg_rd_data = '0;
        case (creg_rd_addr)
            c_creg_addr_status:     creg_rd_data[1:0]        = {r_int_en, r_exe_mode};
            c_creg_addr_pre_status: creg_rd_data[1:0]        = {r_pre_int_en, r_pre_exe_mode};
            c_creg_addr_epc:        creg_rd_data             = {r_epc, 2'b00};
            c_creg_addr_exp_vector: creg_rd_data             = {r_exp_vector, 2'b00};
            c_creg_addr_cause:      creg_rd_data[2:0]        = r_cause;
            c_creg_addr_irq_mask:   creg_rd_data[IRQ_CH-1:0] = r_irq_mask;
            c_creg_addr_irq:        creg_rd_data[IRQ_CH-1:0] = w_irq_sync;
            default:                creg_rd_data             = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush / redirect
    // ------------------------------------------------------------------
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        new_pc    = '0;
        // Outputs stay quiet while reset is asserted regardless of inputs.
        if (reset_) begin
            if (w_busy) begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
            end else if (w_exp || w_exrt || w_wrcr) begin
                // A redirect discards everything younger, including any
                // instruction that the load-use hazard would have held.
                if_flush  = 1'b1;
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
                if (w_exp) begin
                    new_pc = r_exp_vector;
                end else if (w_exrt) begin
                    new_pc = r_epc;
                end else begin
                    new_pc = mem_pc + 30'd1;   // refetch after CREG write
                end
            end else if (ld_hazard) begin
                // Hold IF/ID and inject a bubble into EX.
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Scoreboard testbench for pipeline_ctrl. Stimulus pushes
//                expected redirects and probe values; a monitor process
//                pops and compares on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int IRQ_CH     = 8;
    localparam int SYNC_DEPTH = 2;

    localparam int K_CTL  = 0;
    localparam int K_RD   = 1;
    localparam int K_MODE = 2;
    localparam int K_INT  = 3;
    localparam int K_NPC  = 4;

    logic              clk;
    logic              reset_;
    logic [4:0]        creg_rd_addr;
    logic [31:0]       creg_rd_data;
    logic              exe_mode;
    logic [IRQ_CH-1:0] irq;
    logic              int_detect;
    logic              if_busy;
    logic              ld_hazard;
    logic              mem_busy;
    logic              mem_en;
    logic [29:0]       mem_pc;
    logic [1:0]        mem_ctrl_op;
    logic [4:0]        mem_dst_addr;
    logic [31:0]       mem_out;
    logic [2:0]        mem_exp_code;
    logic              if_stall, id_stall, ex_stall, mem_stall;
    logic              if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0]       new_pc;

    pipeline_ctrl #(
        .IRQ_CH     (IRQ_CH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .creg_rd_addr (creg_rd_addr),
        .creg_rd_data (creg_rd_data),
        .exe_mode     (exe_mode),
        .irq          (irq),
        .int_detect   (int_detect),
        .if_busy      (if_busy),
        .ld_hazard    (ld_hazard),
        .mem_busy     (mem_busy),
        .mem_en       (mem_en),
        .mem_pc       (mem_pc),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_dst_addr (mem_dst_addr),
        .mem_out      (mem_out),
        .mem_exp_code (mem_exp_code),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ex_flush     (ex_flush),
        .mem_flush    (mem_flush),
        .new_pc       (new_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        probe_q[$];
    logic [29:0] redir_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every falling edge, consume redirects the DUT presents and
    // all probes queued for this cycle.
    always @(negedge clk) begin
        if (if_flush) begin
            if (redir_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect actual=%h expected=none", new_pc);
            end else begin
                check("redirect_pc", {2'b00, new_pc}, {2'b00, redir_q.pop_front()});
            end
        end
        if (redir_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_redirect actual=none expected=%h", redir_q[0]);
            redir_q.delete();
        end
        while (probe_q.size() > 0) begin
            mon_e = probe_q.pop_front();
            case (mon_e.kind)
                K_CTL:   mon_act = {24'b0, if_stall, id_stall, ex_stall, mem_stall,
                                    if_flush, id_flush, ex_flush, mem_flush};
                K_RD:    mon_act = creg_rd_data;
                K_MODE:  mon_act = {31'b0, exe_mode};
                K_INT:   mon_act = {31'b0, int_detect};
                default: mon_act = {2'b00, new_pc};
            endcase
            check(mon_e.name, mon_act, mon_e.val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_en       = 1'b0;
        mem_ctrl_op  = 2'd0;
        mem_exp_code = 3'd0;
        if_busy      = 1'b0;
        mem_busy     = 1'b0;
        ld_hazard    = 1'b0;
    endtask

    task automatic push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        probe_q.push_back(e);
    endtask

    // {if,id,ex,mem stall, if,id,ex,mem flush}
    task automatic exp_ctl(input string n, input logic [7:0] v);
        push(K_CTL, {24'b0, v}, n);
    endtask

    task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] v);
        creg_rd_addr = a;
        push(K_RD, v, n);
    endtask

    task automatic wrcr(input logic [29:0] pc, input logic [4:0] a, input logic [31:0] d);
        mem_en       = 1'b1;
        mem_ctrl_op  = 2'd1;
        mem_pc       = pc;
        mem_dst_addr = a;
        mem_out      = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_       = 1'b0;
        irq          = '0;
        creg_rd_addr = 5'd0;
        mem_pc       = '0;
        mem_dst_addr = '0;
        mem_out      = '0;
        idle();

        // Reset: outputs quiet even with an exception presented.
        next_cycle();
        mem_en = 1'b1; mem_exp_code = 3'd2; ld_hazard = 1'b1;
        exp_ctl("reset_ctl", 8'h00);
        push(K_NPC, 32'h0, "reset_new_pc");
        exp_rd("reset_irq_mask", 5'd5, 32'h0000_00FF);
        push(K_MODE, 32'h0, "reset_mode");
        next_cycle();
        idle();
        exp_rd("reset_status", 5'd0, 32'h0);
        next_cycle();
        reset_ = 1'b1;
        exp_rd("reset_exp_vector", 5'd3, 32'h0);
        exp_ctl("idle_ctl", 8'h00);

        // WRCR EXP_VECTOR (byte bits dropped), then STATUS with PC wrap.
        next_cycle();
        wrcr(30'h10, 5'd3, 32'h0000_4003);
        exp_ctl("wrcr_ctl", 8'h0F);
        redir_q.push_back(30'h11);
        next_cycle();
        wrcr(30'h3FFF_FFFF, 5'd0, 32'h3);
        exp_rd("exp_vector_rd", 5'd3, 32'h0000_4000);
        exp_ctl("wrcr_wrap_ctl", 8'h0F);
        redir_q.push_back(30'h0);

        // Load-use hazard.
        next_cycle();
        idle(); ld_hazard = 1'b1;
        exp_ctl("load_use_ctl", 8'hC4);
        exp_rd("status_user", 5'd0, 32'h3);
        push(K_MODE, 32'h1, "mode_user");

        // Busy with hazard and a pending WRCR: all stall, write deferred.
        next_cycle();
        if_busy = 1'b1; ld_hazard = 1'b1;
        wrcr(30'h40, 5'd0, 32'h0);
        exp_ctl("busy_ctl", 8'hF0);
        next_cycle();
        idle();
        exp_rd("busy_no_write", 5'd0, 32'h3);

        // UNDEF at 0x100 in user mode, load-use hazard in same cycle.
        next_cycle();
        mem_en = 1'b1; mem_pc = 30'h100; mem_exp_code = 3'd2; ld_hazard = 1'b1;
        exp_ctl("undef_ctl", 8'h0F);
        redir_q.push_back(30'h1000);
        exp_rd("epc_old_during_exc", 5'd2, 32'h0);
        next_cycle();
        idle();
        exp_rd("undef_epc", 5'd2, 32'h0000_0400);
        push(K_MODE, 32'h0, "undef_mode_kernel");
        next_cycle();
        exp_rd("undef_cause", 5'd4, 32'h2);
        next_cycle();
        exp_rd("undef_pre_status", 5'd1, 32'h3);
        next_cycle();
        exp_rd("undef_status", 5'd0, 32'h0);

        // EXRT returns to 0x100 in user mode with int_en restored.
        next_cycle();
        mem_en = 1'b1; mem_ctrl_op = 2'd2; mem_pc = 30'h180;
        exp_ctl("exrt_ctl", 8'h0F);
        redir_q.push_back(30'h100);
        next_cycle();
        idle();
        exp_rd("exrt_status", 5'd0, 32'h3);
        push(K_MODE, 32'h1, "exrt_mode_user");

        // Unmask irq[0], pulse irq[1:0]; irq[1] stays masked.
        next_cycle();
        wrcr(30'h200, 5'd5, 32'h0000_00FE);
        redir_q.push_back(30'h201);
        next_cycle();
        idle(); irq = 8'h03;
        exp_rd("irq_mask_rd", 5'd5, 32'h0000_00FE);
        push(K_INT, 32'h0, "int_lat0");
        next_cycle();
        irq = 8'h00;
        push(K_INT, 32'h0, "int_lat1");
        next_cycle();
        push(K_INT, 32'h1, "int_detect");
        exp_rd("irq_rd", 5'd6, 32'h0000_0003);
        mem_en = 1'b1; mem_pc = 30'h300;
        exp_ctl("irq_exc_ctl", 8'h0F);
        redir_q.push_back(30'h1000);
        next_cycle();
        idle();
        push(K_INT, 32'h0, "int_cleared");
        exp_rd("irq_cause", 5'd4, 32'h1);
        next_cycle();
        exp_rd("irq_epc", 5'd2, 32'h0000_0C00);
        push(K_MODE, 32'h0, "irq_mode_kernel");
        next_cycle();
        exp_rd("irq_pre_status", 5'd1, 32'h3);

        // Exception deferred while mem_busy, taken when busy drops.
        next_cycle();
        mem_busy = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd6; mem_pc = 30'h400;
        exp_ctl("defer_ctl0", 8'hF0);
        next_cycle();
        exp_ctl("defer_ctl1", 8'hF0);
        next_cycle();
        mem_busy = 1'b0;
        exp_ctl("defer_taken_ctl", 8'h0F);
        redir_q.push_back(30'h1000);
        next_cycle();
        idle();
        exp_rd("defer_cause", 5'd4, 32'h6);
        next_cycle();
        exp_rd("defer_epc", 5'd2, 32'h0000_1000);
        next_cycle();
        exp_rd("defer_pre_status", 5'd1, 32'h0);

        // Exception code with mem_en=0 is ignored.
        next_cycle();
        mem_exp_code = 3'd2;
        exp_ctl("no_mem_en_ctl", 8'h00);

        // WRCR to read-only IRQ register is discarded.
        next_cycle();
        idle();
        wrcr(30'h500, 5'd6, 32'hFFFF_FFFF);
        redir_q.push_back(30'h501);
        next_cycle();
        idle();
        exp_rd("irq_ro", 5'd6, 32'h0);

        // Reset asserted during a WRCR to EXP_VECTOR.
        next_cycle();
        wrcr(30'h600, 5'd3, 32'h0000_8888);
        reset_ = 1'b0;
        exp_ctl("reset_mid_ctl", 8'h00);
        next_cycle();
        idle();
        reset_ = 1'b1;
        exp_rd("reset_mid_exp_vector", 5'd3, 32'h0);
        next_cycle();
        exp_rd("reset_mid_irq_mask", 5'd5, 32'h0000_00FF);
        push(K_MODE, 32'h0, "reset_mid_mode");

        next_cycle();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
